odometry_window_ctrl: RTL and testbench

Windowed tick sampler for the left/right wheel encoders in the Position subsystem. Synchronizes raw encoder pulses, counts rising edges per wheel over a fixed window of clock cycles, then latches both counts into a sample register. The navigation logic reads the sample register through a valid/ack handshake. Start/stop control, saturation and overrun reporting are sequenced here, so downstream logic never sees a half-updated pair.

---
 rtl/odometry_pkg.sv | 15 +
 rtl/edge_sync.sv | 38 +++
 rtl/odometry_window_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_odometry_window_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odometry_pkg.sv
// Shared definitions for the wheel-odometry window sampler.
//   state_e      : controller state (StIdle, StRun)
//   WinIdW       : width of the window sequence number
//   DefaultCntW  : default per-wheel tick counter width
package odometry_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned WinIdW      = 8;
    localparam int unsigned DefaultCntW = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw encoder line.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : raw encoder level, asynchronous to clk_i
//   pulse_o : one-cycle pulse per synchronized rising edge
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Pulse is formed from registered values only, so it is glitch-free.
    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/odometry_window_ctrl.sv
// Windowed tick sampler for left/right wheel encoders.
// Counts synchronized rising edges per wheel over WINDOW_CYCLES clocks while running, then
// latches both counts (plus saturation flags and a sequence number) into a sample register
// that the consumer drains with a valid/ack handshake. A closed window that finds the sample
// register still full is dropped and reported through the sticky overrun flag.
// Ports:
//   clk, rst (async, active low)
//   enc_l, enc_r        : raw encoder pulses
//   start, stop         : single-cycle control pulses (stop has priority)
//   rd_ack              : consumer accepts the current sample
//   busy                : controller is running
//   sample_valid        : sample register holds an unread sample
//   ticks_l, ticks_r    : latched tick counts
//   sat_l, sat_r        : latched saturation flags
//   window_id           : sequence number of the latched window
//   overrun             : sticky, a completed window was dropped
module odometry_window_ctrl
    import odometry_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100000,
    parameter int unsigned CNT_W         = DefaultCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_l,
    input  logic              enc_r,
    input  logic              start,
    input  logic              stop,
    input  logic              rd_ack,
    output logic              busy,
    output logic              sample_valid,
    output logic [CNT_W-1:0]  ticks_l,
    output logic [CNT_W-1:0]  ticks_r,
    output logic              sat_l,
    output logic              sat_r,
    output logic [WinIdW-1:0] window_id,
    output logic              overrun
);

    localparam int unsigned WinCntW = $clog2(WINDOW_CYCLES);
    localparam logic [WinCntW-1:0] WinLast = WinCntW'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};

    logic pulse_l, pulse_r;

    edge_sync u_sync_l (
        .clk_i   (clk),
        .rst_ni  (rst),
        .raw_i   (enc_l),
        .pulse_o (pulse_l)
    );

    edge_sync u_sync_r (
        .clk_i   (clk),
        .rst_ni  (rst),
        .raw_i   (enc_r),
        .pulse_o (pulse_r)
    );

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic [WinCntW-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
    logic                run_sat_l_q, run_sat_l_d, run_sat_r_q, run_sat_r_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    ticks_l_q, ticks_l_d, ticks_r_q, ticks_r_d;
    logic                sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic [WinIdW-1:0]   win_id_q, win_id_d;
    logic                overrun_q, overrun_d;

    // Running counts including this cycle's pulse, so a tick on the terminal cycle
    // lands in the window that is closing.
    logic [CNT_W-1:0]    cnt_l_nxt, cnt_r_nxt;
    logic                sat_l_nxt, sat_r_nxt;
    logic                load;

    always_comb begin
        cnt_l_nxt = cnt_l_q;
        sat_l_nxt = run_sat_l_q;
        if (pulse_l) begin
            if (cnt_l_q == CntMax) sat_l_nxt = 1'b1;
            else                   cnt_l_nxt = cnt_l_q + CNT_W'(1);
        end
        cnt_r_nxt = cnt_r_q;
        sat_r_nxt = run_sat_r_q;
        if (pulse_r) begin
            if (cnt_r_q == CntMax) sat_r_nxt = 1'b1;
            else                   cnt_r_nxt = cnt_r_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        cnt_l_d     = cnt_l_q;
        cnt_r_d     = cnt_r_q;
        run_sat_l_d = run_sat_l_q;
        run_sat_r_d = run_sat_r_q;
        valid_d     = valid_q;
        ticks_l_d   = ticks_l_q;
        ticks_r_d   = ticks_r_q;
        sat_l_d     = sat_l_q;
        sat_r_d     = sat_r_q;
        win_id_d    = win_id_q;
        overrun_d   = overrun_q;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d     = StRun;
                    win_cnt_d   = '0;
                    cnt_l_d     = '0;
                    cnt_r_d     = '0;
                    run_sat_l_d = 1'b0;
                    run_sat_r_d = 1'b0;
                    overrun_d   = 1'b0;
                end
            end
            StRun: begin
                if (stop) begin
                    // Partial window is abandoned; counters are cleared on the next start.
                    state_d = StIdle;
                end else if (win_cnt_q == WinLast) begin
                    win_cnt_d   = '0;
                    cnt_l_d     = '0;
                    cnt_r_d     = '0;
                    run_sat_l_d = 1'b0;
                    run_sat_r_d = 1'b0;
                    if (!valid_q || rd_ack) begin
                        load      = 1'b1;
                        ticks_l_d = cnt_l_nxt;
                        ticks_r_d = cnt_r_nxt;
                        sat_l_d   = sat_l_nxt;
                        sat_r_d   = sat_r_nxt;
                        win_id_d  = win_id_q + WinIdW'(1);
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    win_cnt_d   = win_cnt_q + WinCntW'(1);
                    cnt_l_d     = cnt_l_nxt;
                    cnt_r_d     = cnt_r_nxt;
                    run_sat_l_d = sat_l_nxt;
                    run_sat_r_d = sat_r_nxt;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh load takes precedence over an ack of the sample it replaces.
        if (load)                   valid_d = 1'b1;
        else if (valid_q && rd_ack) valid_d = 1'b0;

        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            win_cnt_q   <= '0;
            cnt_l_q     <= '0;
            cnt_r_q     <= '0;
            run_sat_l_q <= 1'b0;
            run_sat_r_q <= 1'b0;
            valid_q     <= 1'b0;
            ticks_l_q   <= '0;
            ticks_r_q   <= '0;
            sat_l_q     <= 1'b0;
            sat_r_q     <= 1'b0;
            win_id_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            win_cnt_q   <= win_cnt_d;
            cnt_l_q     <= cnt_l_d;
            cnt_r_q     <= cnt_r_d;
            run_sat_l_q <= run_sat_l_d;
            run_sat_r_q <= run_sat_r_d;
            valid_q     <= valid_d;
            ticks_l_q   <= ticks_l_d;
            ticks_r_q   <= ticks_r_d;
            sat_l_q     <= sat_l_d;
            sat_r_q     <= sat_r_d;
            win_id_q    <= win_id_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign ticks_l      = ticks_l_q;
    assign ticks_r      = ticks_r_q;
    assign sat_l        = sat_l_q;
    assign sat_r        = sat_r_q;
    assign window_id    = win_id_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_odometry_window_ctrl.sv
// Bench for odometry_window_ctrl: directed windows with hand-computed expectations,
// followed by randomized traffic, all checked every cycle against a behavioural model.
module tb_odometry_window_ctrl;

    localparam int WIN  = 40;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enc_l = 1'b0, enc_r = 1'b0;
    logic          start = 1'b0, stop = 1'b0, rd_ack = 1'b0;
    logic          busy, sample_valid, sat_l, sat_r, overrun;
    logic [CW-1:0] ticks_l, ticks_r;
    logic [7:0]    window_id;

    int checks = 0;
    int errors = 0;

    odometry_window_ctrl #(
        .WINDOW_CYCLES (WIN),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .enc_l        (enc_l),
        .enc_r        (enc_r),
        .start        (start),
        .stop         (stop),
        .rd_ack       (rd_ack),
        .busy         (busy),
        .sample_valid (sample_valid),
        .ticks_l      (ticks_l),
        .ticks_r      (ticks_r),
        .sat_l        (sat_l),
        .sat_r        (sat_r),
        .window_id    (window_id),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples history, running window, sample register.
    typedef struct packed {
        bit       run;
        int       win;
        int       cl;
        int       cr;
        bit       sl;
        bit       sr;
        bit       valid;
        int       tl;
        int       tr;
        bit       msl;
        bit       msr;
        int       id;
        bit       ovr;
        bit [2:0] hl;  // [0] = raw level at previous edge, [1] two edges back, [2] three
        bit [2:0] hr;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(input mdl_t c, input bit s, input bit p, input bit a,
                                  input bit l, input bit r);
        mdl_t n;
        bit pl, pr, loaded;
        n = c;
        loaded = 1'b0;
        // A rise first sampled two edges ago is counted on this edge.
        pl = c.hl[1] & ~c.hl[2];
        pr = c.hr[1] & ~c.hr[2];
        n.hl = {c.hl[1:0], l};
        n.hr = {c.hr[1:0], r};
        if (!c.run) begin
            if (s && !p) begin
                n.run = 1'b1; n.win = 0; n.cl = 0; n.cr = 0;
                n.sl = 1'b0; n.sr = 1'b0; n.ovr = 1'b0;
            end
        end else if (p) begin
            n.run = 1'b0;
        end else begin
            if (pl) begin
                if (n.cl == CMAX) n.sl = 1'b1; else n.cl = n.cl + 1;
            end
            if (pr) begin
                if (n.cr == CMAX) n.sr = 1'b1; else n.cr = n.cr + 1;
            end
            if (c.win == WIN - 1) begin
                if (!c.valid || a) begin
                    n.tl = n.cl; n.tr = n.cr; n.msl = n.sl; n.msr = n.sr;
                    n.id = (c.id + 1) % 256;
                    n.valid = 1'b1;
                    loaded = 1'b1;
                end else begin
                    n.ovr = 1'b1;
                end
                n.win = 0; n.cl = 0; n.cr = 0; n.sl = 1'b0; n.sr = 1'b0;
            end else begin
                n.win = c.win + 1;
            end
        end
        if (!loaded && c.valid && a) n.valid = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, start, stop, rd_ack, enc_l, enc_r);
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m.run});
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, m.valid});
        chk("ticks_l", 32'(ticks_l), m.tl);
        chk("ticks_r", 32'(ticks_r), m.tr);
        chk("sat_l", {31'd0, sat_l}, {31'd0, m.msl});
        chk("sat_r", {31'd0, sat_r}, {31'd0, m.msr});
        chk("window_id", 32'(window_id), m.id);
        chk("overrun", {31'd0, overrun}, {31'd0, m.ovr});
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_valid"}, {31'd0, sample_valid}, 0);
        chk({tag, "_ticks_l"}, 32'(ticks_l), 0);
        chk({tag, "_ticks_r"}, 32'(ticks_r), 0);
        chk({tag, "_sat"}, {30'd0, sat_l, sat_r}, 0);
        chk({tag, "_window_id"}, 32'(window_id), 0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 0);
    endtask

    initial begin
        bit lvl_l, lvl_r;
        int hold_l, hold_r;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed windows; case labels are edge offsets after the starting edge.
        for (int t = 0; t <= 215; t++) begin
            @(negedge clk);
            case (t - 1)
                40: begin
                    chk("w1_valid", {31'd0, sample_valid}, 1);
                    chk("w1_ticks_l", 32'(ticks_l), 3);
                    chk("w1_ticks_r", 32'(ticks_r), 5);
                    chk("w1_id", 32'(window_id), 1);
                    chk("w1_sat", {30'd0, sat_l, sat_r}, 0);
                end
                46: chk("ack_clears_valid", {31'd0, sample_valid}, 0);
                80: begin
                    chk("tc_tick_valid", {31'd0, sample_valid}, 1);
                    chk("tc_tick_ticks_l", 32'(ticks_l), 1);
                    chk("tc_tick_ticks_r", 32'(ticks_r), 0);
                    chk("tc_tick_id", 32'(window_id), 2);
                end
                120: begin
                    chk("drop_overrun", {31'd0, overrun}, 1);
                    chk("drop_id", 32'(window_id), 2);
                    chk("drop_ticks_l", 32'(ticks_l), 1);
                end
                160: begin
                    chk("ack_tc_valid", {31'd0, sample_valid}, 1);
                    chk("ack_tc_id", 32'(window_id), 3);
                    chk("ack_tc_ticks_l", 32'(ticks_l), 0);
                    chk("ack_tc_overrun", {31'd0, overrun}, 1);
                end
                166: begin
                    chk("stop_busy", {31'd0, busy}, 0);
                    chk("stop_valid", {31'd0, sample_valid}, 1);
                    chk("stop_id", 32'(window_id), 3);
                end
                170: chk("start_stop_idle", {31'd0, busy}, 0);
                174: begin
                    chk("restart_busy", {31'd0, busy}, 1);
                    chk("restart_overrun", {31'd0, overrun}, 0);
                end
                214: begin
                    chk("sat_valid", {31'd0, sample_valid}, 1);
                    chk("sat_ticks_l", 32'(ticks_l), 7);
                    chk("sat_ticks_r", 32'(ticks_r), 1);
                    chk("sat_flags", {30'd0, sat_l, sat_r}, 32'b10);
                    chk("sat_id", 32'(window_id), 4);
                end
                default: ;
            endcase
            start  = (t == 0) || (t == 170) || (t == 174);
            stop   = (t == 166) || (t == 170);
            rd_ack = (t == 45) || (t == 160) || (t == 172);
            enc_l  = (t >= 1 && t <= 24 && ((t - 1) % 8 < 4)) || t == 78 || t == 79 ||
                     (t >= 175 && t <= 214 && ((t - 175) % 4 < 2));
            enc_r  = (t >= 1 && t <= 20 && ((t - 1) % 4 < 2)) || t == 180 || t == 181;
        end

        // Randomized traffic; encoder levels held at least two cycles.
        lvl_l = enc_l; lvl_r = enc_r; hold_l = 2; hold_r = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold_l >= 2 && $urandom_range(0, 1) == 1) begin
                lvl_l = ~lvl_l; hold_l = 1;
            end else hold_l++;
            if (hold_r >= 2 && $urandom_range(0, 2) == 0) begin
                lvl_r = ~lvl_r; hold_r = 1;
            end else hold_r++;
            enc_l  = lvl_l;
            enc_r  = lvl_r;
            start  = ($urandom_range(0, 15) == 0);
            stop   = ($urandom_range(0, 199) == 0);
            rd_ack = ($urandom_range(0, 2) == 0);
        end

        // Reset mid-window with a sample pending.
        @(negedge clk);
        start = 1'b0; stop = 1'b1; rd_ack = 1'b0; enc_l = 1'b0; enc_r = 1'b0;
        @(negedge clk);
        stop = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (WIN + 5) @(negedge clk);
        chk("pre_reset_valid", {31'd0, sample_valid}, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_valid", {31'd0, sample_valid}, 0);
        chk("post_reset_busy", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
